// File: rtl/sr_latch_sequencer.sv
// SR-latch demonstrator sequencer: steps S/R from a fixed pattern or from switches
// once per divided tick, holds Q as a registered latch, and shows it on a 7-segment digit.
module sr_latch_sequencer #(
    parameter int TICK_DIV = 20000000,
    parameter int CNT_W    = 27
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       manual,
    input  logic       s_in,
    input  logic       r_in,
    output logic       s_out,
    output logic       r_out,
    output logic       q,
    output logic       q_n,
    output logic       invalid,
    output logic       busy,
    output logic       done,
    output logic [2:0] step_idx,
    output logic [6:0] seg,
    output logic       heartbeat
);
    // state | meaning
    // IDLE  | waiting for start; switches drive S/R on each tick when manual=1
    // RUN   | stepping through the 8-entry S/R pattern, one step per tick
    // DONE  | single-cycle completion pulse, S/R released
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [6:0] SEG_ZERO = 7'b0000001;
    localparam logic [6:0] SEG_ONE  = 7'b1001111;
    localparam logic [6:0] SEG_ERR  = 7'b0110000;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             tick;
    logic             s_nxt, r_nxt, q_nxt, inv_nxt;
    logic [2:0]       idx_nxt;
    logic [6:0]       seg_nxt;

    function automatic logic [1:0] rom_sr(input logic [2:0] idx);
        case (idx)
            3'd0:    rom_sr = 2'b10;
            3'd1:    rom_sr = 2'b00;
            3'd2:    rom_sr = 2'b01;
            3'd3:    rom_sr = 2'b00;
            3'd4:    rom_sr = 2'b10;
            3'd5:    rom_sr = 2'b11;
            3'd6:    rom_sr = 2'b00;
            default: rom_sr = 2'b01;
        endcase
    endfunction

    // S=R=1 holds the previous value; the caller flags it as invalid.
    function automatic logic latch_eval(input logic q_cur, input logic s, input logic r);
        case ({s, r})
            2'b10:   latch_eval = 1'b1;
            2'b01:   latch_eval = 1'b0;
            default: latch_eval = q_cur;
        endcase
    endfunction

    assign tick = (cnt == CNT_W'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            heartbeat <= 1'b0;
        end else if (tick) begin
            cnt       <= '0;
            heartbeat <= ~heartbeat;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && !manual) state_nxt = RUN;
            RUN:     if (tick && step_idx == 3'd7) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s_nxt   = s_out;
        r_nxt   = r_out;
        q_nxt   = q;
        inv_nxt = invalid;
        idx_nxt = step_idx;
        case (state)
            IDLE: begin
                if (start && !manual) begin
                    idx_nxt        = 3'd0;
                    {s_nxt, r_nxt} = rom_sr(3'd0);
                    inv_nxt        = 1'b0;
                end else if (manual && tick) begin
                    s_nxt = s_in;
                    r_nxt = r_in;
                    q_nxt = latch_eval(q, s_in, r_in);
                    if (s_in && r_in) inv_nxt = 1'b1;
                end
            end
            RUN: begin
                if (tick) begin
                    q_nxt = latch_eval(q, s_out, r_out);
                    if (s_out && r_out) inv_nxt = 1'b1;
                    if (step_idx != 3'd7) begin
                        idx_nxt        = step_idx + 3'd1;
                        {s_nxt, r_nxt} = rom_sr(step_idx + 3'd1);
                    end else begin
                        s_nxt = 1'b0;
                        r_nxt = 1'b0;
                    end
                end
            end
            default: begin
                s_nxt = 1'b0;
                r_nxt = 1'b0;
            end
        endcase
        // The error glyph is only meaningful while a sequence is being shown.
        if (invalid && state != IDLE) seg_nxt = SEG_ERR;
        else if (q)                   seg_nxt = SEG_ONE;
        else                          seg_nxt = SEG_ZERO;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_out    <= 1'b0;
            r_out    <= 1'b0;
            q        <= 1'b0;
            invalid  <= 1'b0;
            step_idx <= 3'd0;
            seg      <= SEG_ZERO;
        end else begin
            s_out    <= s_nxt;
            r_out    <= r_nxt;
            q        <= q_nxt;
            invalid  <= inv_nxt;
            step_idx <= idx_nxt;
            seg      <= seg_nxt;
        end
    end

    assign q_n  = ~q;
    assign busy = (state == RUN);
    assign done = (state == DONE);
endmodule

// File: tb/tb_sr_latch_sequencer.sv
// Directed bench for sr_latch_sequencer with TICK_DIV=4; expected values are hand-derived
// from the step pattern and a bench-side tick counter.
module tb_sr_latch_sequencer;
    localparam logic [6:0] SEG_ZERO = 7'b0000001;
    localparam logic [6:0] SEG_ONE  = 7'b1001111;
    localparam logic [6:0] SEG_ERR  = 7'b0110000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, manual = 1'b0, s_in = 1'b0, r_in = 1'b0;
    logic       s_out, r_out, q, q_n, invalid, busy, done, heartbeat;
    logic [2:0] step_idx;
    logic [6:0] seg;

    int         n_chk = 0;
    int         n_bad = 0;
    int         done_cnt = 0;
    int         tcnt = 0;
    logic       tick_m;
    logic [7:0] q_trace;

    sr_latch_sequencer #(.TICK_DIV(4), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .start(start), .manual(manual), .s_in(s_in), .r_in(r_in),
        .s_out(s_out), .r_out(r_out), .q(q), .q_n(q_n), .invalid(invalid), .busy(busy),
        .done(done), .step_idx(step_idx), .seg(seg), .heartbeat(heartbeat)
    );

    always #5 clk = ~clk;

    // Reference tick phase: count 0..3, tick in the cycle the count is 3.
    always @(posedge clk) begin
        if (rst)            tcnt <= 0;
        else if (tcnt == 3) tcnt <= 0;
        else                tcnt <= tcnt + 1;
    end
    assign tick_m = (tcnt == 3);

    always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_chk++;
        if (obs !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance until just past the next tick edge.
    task automatic next_tick();
        while (!tick_m) step();
        step();
    endtask

    task automatic run_auto(input string tag);
        int d0;
        d0 = done_cnt;
        start = 1'b1;
        step();
        start = 1'b0;
        chk({tag, " busy0"}, busy, 1);
        chk({tag, " idx0"}, step_idx, 0);
        chk({tag, " sr0"}, {s_out, r_out}, 2'b10);
        for (int k = 0; k < 8; k++) begin
            next_tick();
            chk($sformatf("%s q%0d", tag, k), q, q_trace[k]);
            chk($sformatf("%s qn%0d", tag, k), q_n, !q_trace[k]);
            if (k < 7) begin
                chk($sformatf("%s idx%0d", tag, k), step_idx, k + 1);
                chk($sformatf("%s inv%0d", tag, k), invalid, (k >= 5) ? 1 : 0);
                chk($sformatf("%s busy%0d", tag, k), busy, 1);
                step();
                chk($sformatf("%s seg%0d", tag, k), seg,
                    (k >= 5) ? SEG_ERR : (q_trace[k] ? SEG_ONE : SEG_ZERO));
            end else begin
                chk({tag, " done"}, done, 1);
                chk({tag, " busy_end"}, busy, 0);
                chk({tag, " sr_end"}, {s_out, r_out}, 2'b00);
            end
        end
        step();
        chk({tag, " done_off"}, done, 0);
        step();
        chk({tag, " seg_idle"}, seg, SEG_ZERO);
        chk({tag, " done_once"}, done_cnt - d0, 1);
    endtask

    task automatic ticks_to_done(input string tag, input int already);
        int n;
        n = already;
        while (done !== 1'b1 && n < 20) begin
            next_tick();
            n++;
        end
        chk({tag, " run_len"}, n, 8);
    endtask

    initial begin
        int d0;
        q_trace = 8'b01110011;

        // Reset
        step();
        step();
        rst = 1'b0;
        chk("rst q", q, 0);
        chk("rst qn", q_n, 1);
        chk("rst seg", seg, SEG_ZERO);
        chk("rst busy", busy, 0);
        chk("rst hb", heartbeat, 0);
        chk("rst idx", step_idx, 0);
        chk("rst sr", {s_out, r_out}, 2'b00);
        chk("rst inv_done", {invalid, done}, 2'b00);
        next_tick();
        chk("hb rise", heartbeat, 1);
        step(); step(); step();
        chk("hb hold", heartbeat, 1);
        step();
        chk("hb fall", heartbeat, 0);

        // Auto run
        run_auto("auto");

        // Manual mode, with start ignored while manual=1
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("man rst inv", invalid, 0);
        manual = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("man start_ign", busy, 0);
        s_in = 1'b1; r_in = 1'b0;
        next_tick();
        chk("man set q", q, 1);
        chk("man set sr", {s_out, r_out}, 2'b10);
        step();
        chk("man set seg", seg, SEG_ONE);
        s_in = 1'b0; r_in = 1'b1;
        next_tick();
        chk("man rst q", q, 0);
        s_in = 1'b1; r_in = 1'b1;
        next_tick();
        chk("man 11 q", q, 0);
        chk("man 11 inv", invalid, 1);
        step();
        chk("man 11 seg", seg, SEG_ZERO);

        // Ignored start during RUN
        manual = 1'b0;
        s_in = 1'b0; r_in = 1'b0;
        step();
        d0 = done_cnt;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("ign busy", busy, 1);
        next_tick();
        next_tick();
        chk("ign idx2", step_idx, 2);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("ign idx_a", step_idx, 2);
        chk("ign busy_a", busy, 1);
        manual = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("ign idx_b", step_idx, 2);
        manual = 1'b0;
        ticks_to_done("ign", 2);
        step(); step();
        chk("ign done_once", done_cnt - d0, 1);

        // Mid-run reset
        start = 1'b1;
        step();
        start = 1'b0;
        next_tick(); next_tick(); next_tick();
        chk("mid idx3", step_idx, 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid q", q, 0);
        chk("mid qn", q_n, 1);
        chk("mid busy", busy, 0);
        chk("mid idx", step_idx, 0);
        chk("mid sr", {s_out, r_out}, 2'b00);
        chk("mid seg", seg, SEG_ZERO);
        chk("mid hb", heartbeat, 0);
        chk("mid inv_done", {invalid, done}, 2'b00);
        run_auto("rerun");

        // Start coincident with tick
        while (!tick_m) step();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("coin busy", busy, 1);
        chk("coin idx_a", step_idx, 0);
        step(); step();
        chk("coin idx_b", step_idx, 0);
        ticks_to_done("coin", 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
